pipeline_hazard_ctrl: RTL and testbench

Central sequencing controller for the 5-stage pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives per-latch enable and flush (bubble insert) plus the PC write enable.
- Handles memory-wait stalls, load-use stalls, taken-branch/jump flushes and halt draining.
- Sits beside the latches, fed by decode, execute and the memory-hit signals.

---
 rtl/pipeline_hazard_ctrl_if.sv | 46 ++++
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and latch controls between the pipeline and its sequencing controller
// master: pipeline side (drives decode/execute/memory status, receives latch controls)
// slave:  hazard controller side
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int PERF_CW = 16
);
  logic              ihit;
  logic              dhit;
  logic              exmem_dmemREN;
  logic              exmem_dmemWEN;
  logic              idex_dmemREN;
  logic [REG_AW-1:0] idex_rd;
  logic [REG_AW-1:0] ifid_rs;
  logic [REG_AW-1:0] ifid_rt;
  logic              ifid_uses_rt;
  logic              ex_redirect;
  logic              halt_id;
  logic              halt_wb;

  logic               pc_en;
  logic               ifid_en;
  logic               idex_en;
  logic               exmem_en;
  logic               memwb_en;
  logic               ifid_flush;
  logic               idex_flush;
  logic               exmem_flush;
  logic               halted;
  logic [PERF_CW-1:0] stall_cycles;
  logic [PERF_CW-1:0] flush_events;

  modport master (
    output ihit, dhit, exmem_dmemREN, exmem_dmemWEN, idex_dmemREN,
           idex_rd, ifid_rs, ifid_rt, ifid_uses_rt, ex_redirect, halt_id, halt_wb,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cycles, flush_events
  );

  modport slave (
    input  ihit, dhit, exmem_dmemREN, exmem_dmemWEN, idex_dmemREN,
           idex_rd, ifid_rs, ifid_rt, ifid_uses_rt, ex_redirect, halt_id, halt_wb,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline latch sequencing controller; HAZARD_PERF_EN adds stall/flush counters
module pipeline_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int PERF_CW = 16
) (
  input logic                   CLK,
  input logic                   RST,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  state_t state, state_nxt;

  logic mem_stall;
  logic load_use;
  logic redirect_go;

  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c, halted_c;

  // A pending data access freezes everything; a redirect is only honoured once it is free to move.
  assign mem_stall   = (hz.exmem_dmemREN | hz.exmem_dmemWEN) & ~hz.dhit;
  assign load_use    = hz.idex_dmemREN & (hz.idex_rd != ZERO_REG) &
                       ((hz.idex_rd == hz.ifid_rs) |
                        (hz.ifid_uses_rt & (hz.idex_rd == hz.ifid_rt)));
  assign redirect_go = hz.ex_redirect & ~mem_stall & (state != HALTED);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state: a redirect always beats a halt, since the halt sits in its shadow
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hz.halt_id & ~mem_stall & ~hz.ex_redirect) state_nxt = DRAIN;
      DRAIN: begin
        if (redirect_go)                  state_nxt = RUN;
        else if (hz.halt_wb & ~mem_stall) state_nxt = HALTED;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // Output decode; a flush always comes with its latch enable so the bubble is loaded
  always_comb begin
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    halted_c      = 1'b0;
    if (!RST) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            pc_en_c = 1'b0;
          end else if (hz.ex_redirect) begin
            pc_en_c      = hz.ihit;
            ifid_en_c    = 1'b1;
            idex_en_c    = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
          end else if (load_use) begin
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
          end else if (!hz.ihit) begin
            ifid_en_c    = 1'b1;
            ifid_flush_c = 1'b1;
            idex_en_c    = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
          end else begin
            pc_en_c    = 1'b1;
            ifid_en_c  = 1'b1;
            idex_en_c  = 1'b1;
            exmem_en_c = 1'b1;
            memwb_en_c = 1'b1;
          end
        end
        DRAIN: begin
          // Nothing new enters behind the halt; the front latch is bubbled every cycle.
          ifid_en_c    = 1'b1;
          ifid_flush_c = 1'b1;
          if (mem_stall) begin
            pc_en_c = 1'b0;
          end else if (hz.ex_redirect) begin
            pc_en_c      = hz.ihit;
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
          end else if (load_use) begin
            idex_en_c    = 1'b1;
            idex_flush_c = 1'b1;
            exmem_en_c   = 1'b1;
            memwb_en_c   = 1'b1;
          end else begin
            idex_en_c  = 1'b1;
            exmem_en_c = 1'b1;
            memwb_en_c = 1'b1;
          end
        end
        HALTED:  halted_c = 1'b1;
        default: halted_c = 1'b0;
      endcase
    end
  end

  assign hz.pc_en       = pc_en_c;
  assign hz.ifid_en     = ifid_en_c;
  assign hz.idex_en     = idex_en_c;
  assign hz.exmem_en    = exmem_en_c;
  assign hz.memwb_en    = memwb_en_c;
  assign hz.ifid_flush  = ifid_flush_c;
  assign hz.idex_flush  = idex_flush_c;
  assign hz.exmem_flush = exmem_flush_c;
  assign hz.halted      = halted_c;

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_CW-1:0] CNT_ONE = {{(PERF_CW-1){1'b0}}, 1'b1};

  logic [PERF_CW-1:0] stall_q;
  logic [PERF_CW-1:0] flush_q;

  // Saturating counters of PC-stalled cycles and acted-on redirects
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en_c && (state != HALTED) && (stall_q != '1)) stall_q <= stall_q + CNT_ONE;
      if (redirect_go && (flush_q != '1))                   flush_q <= flush_q + CNT_ONE;
    end
  end

  assign hz.stall_cycles = RST ? '0 : stall_q;
  assign hz.flush_events = RST ? '0 : flush_q;
`else
  assign hz.stall_cycles = {PERF_CW{1'b0}};
  assign hz.flush_events = {PERF_CW{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and randomized check of pipeline_hazard_ctrl against a stage-action model
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW  = 5;
  localparam int PERF_CW = 16;

  logic CLK;
  logic RST;

  int n_compared;
  int n_mismatched;

  // model state: pipeline mode and perf counts
  bit m_draining;
  bit m_halted;
  int m_stall;
  int m_flush;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .PERF_CW(PERF_CW)) hif ();

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .PERF_CW(PERF_CW)) dut (
    .CLK (CLK),
    .RST (RST),
    .hz  (hif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Per-stage action: 0 = hold, 1 = load, 2 = bubble. Returns the expected control vector
  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halted}.
  function automatic logic [8:0] model_ctl(output bit pc, output bit redirect_taken);
    int  act [4];
    bit  busy, raw, hlt;
    logic [8:0] v;
    pc = 0;
    redirect_taken = 0;
    hlt = 0;
    for (int i = 0; i < 4; i++) act[i] = 0;
    busy = (hif.exmem_dmemREN || hif.exmem_dmemWEN) && !hif.dhit;
    raw  = hif.idex_dmemREN && (hif.idex_rd != 0) &&
           ((hif.idex_rd == hif.ifid_rs) || (hif.ifid_uses_rt && (hif.idex_rd == hif.ifid_rt)));
    if (RST) begin
      hlt = 0;
    end else if (m_halted) begin
      hlt = 1;
    end else if (busy) begin
      if (m_draining) act[0] = 2;
    end else if (hif.ex_redirect) begin
      act[0] = 2; act[1] = 2; act[2] = 1; act[3] = 1;
      pc = hif.ihit;
      redirect_taken = 1;
    end else if (raw) begin
      act[0] = m_draining ? 2 : 0;
      act[1] = 2; act[2] = 1; act[3] = 1;
    end else begin
      act[1] = 1; act[2] = 1; act[3] = 1;
      act[0] = (m_draining || !hif.ihit) ? 2 : 1;
      pc = !m_draining && hif.ihit;
    end
    v = {pc, act[0] != 0, act[1] != 0, act[2] != 0, act[3] != 0,
         act[0] == 2, act[1] == 2, act[2] == 2, hlt};
    return v;
  endfunction

  task automatic model_advance(input bit pc, input bit redirect_taken);
    bit busy;
    busy = (hif.exmem_dmemREN || hif.exmem_dmemWEN) && !hif.dhit;
    if (RST) begin
      m_draining = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else if (!m_halted) begin
      if (!pc && m_stall < 65535) m_stall++;
      if (redirect_taken && m_flush < 65535) m_flush++;
      if (m_draining) begin
        if (redirect_taken) m_draining = 0;
        else if (hif.halt_wb && !busy) begin m_draining = 0; m_halted = 1; end
      end else if (hif.halt_id && !busy && !hif.ex_redirect) begin
        m_draining = 1;
      end
    end
  endtask

  // Inputs are set at a negedge; compare after settling, advance the model, move to next negedge.
  task automatic step(input string tag);
    logic [8:0]  exp;
    logic [31:0] exp_s, exp_f;
    bit pc, rt;
    #1;
    exp = model_ctl(pc, rt);
`ifdef HAZARD_PERF_EN
    exp_s = m_stall;
    exp_f = m_flush;
`else
    exp_s = 0;
    exp_f = 0;
`endif
    check({tag, "/ctl"}, {23'd0, hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                          hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.halted}, {23'd0, exp});
    check({tag, "/stall_cycles"}, {16'd0, hif.stall_cycles}, exp_s);
    check({tag, "/flush_events"}, {16'd0, hif.flush_events}, exp_f);
    model_advance(pc, rt);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    hif.ihit = 1; hif.dhit = 1;
    hif.exmem_dmemREN = 0; hif.exmem_dmemWEN = 0; hif.idex_dmemREN = 0;
    hif.idex_rd = 0; hif.ifid_rs = 0; hif.ifid_rt = 0; hif.ifid_uses_rt = 0;
    hif.ex_redirect = 0; hif.halt_id = 0; hif.halt_wb = 0;
  endtask

  initial begin
    n_compared = 0; n_mismatched = 0;
    m_draining = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    RST = 1;
    idle_inputs();
    @(negedge CLK);
    step("reset0");
    step("reset1");
    RST = 0;

    // load-use on rs, then the load moves on
    hif.idex_dmemREN = 1; hif.idex_rd = 3; hif.ifid_rs = 3;
    step("loaduse");
    check("loaduse/pc_en_prev", {31'd0, m_stall > 0}, 32'd1);
    hif.idex_dmemREN = 0;
    step("loaduse_after");
    check("loaduse_after/pc_en", {31'd0, hif.pc_en}, 32'd1);

    // r0 and unused rt are never hazards
    hif.idex_dmemREN = 1; hif.idex_rd = 0; hif.ifid_rs = 0;
    step("rd_zero");
    hif.idex_rd = 3; hif.ifid_rs = 5; hif.ifid_rt = 3; hif.ifid_uses_rt = 0;
    step("rt_unused");
    hif.ifid_uses_rt = 1;
    step("rt_used");
    idle_inputs();

    // redirect held behind a 3-cycle data wait
    hif.exmem_dmemREN = 1; hif.dhit = 0; hif.ex_redirect = 1;
    for (int i = 0; i < 3; i++) step("memwait_redirect");
    hif.dhit = 1;
    step("redirect_release");
    idle_inputs();

    // two fetch-wait cycles
    hif.ihit = 0;
    step("fetchwait0");
    step("fetchwait1");
    idle_inputs();

    // halt in a branch shadow
    hif.halt_id = 1;
    step("halt_enter");
    hif.halt_id = 0; hif.ex_redirect = 1; hif.ihit = 0;
    step("drain_redirect");
    idle_inputs();
    step("back_to_run");

    // full halt drain, then reset
    hif.halt_id = 1;
    step("halt2_enter");
    hif.halt_id = 0;
    step("drain0");
    step("drain1");
    hif.halt_wb = 1;
    step("drain_wb");
    hif.halt_wb = 0; hif.ex_redirect = 1;
    step("halted0");
    check("halted0/halted", {31'd0, hif.halted}, 32'd1);
    step("halted1");
    RST = 1;
    step("halt_reset");
    RST = 0; hif.ex_redirect = 0;
    step("after_reset");

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      RST               = ($urandom_range(0, 39) == 0);
      hif.ihit          = ($urandom_range(0, 3) != 0);
      hif.dhit          = $urandom_range(0, 1);
      hif.exmem_dmemREN = ($urandom_range(0, 3) == 0);
      hif.exmem_dmemWEN = ($urandom_range(0, 3) == 0);
      hif.idex_dmemREN  = ($urandom_range(0, 2) == 0);
      hif.idex_rd       = REG_AW'($urandom_range(0, 3));
      hif.ifid_rs       = REG_AW'($urandom_range(0, 3));
      hif.ifid_rt       = REG_AW'($urandom_range(0, 3));
      hif.ifid_uses_rt  = $urandom_range(0, 1);
      hif.ex_redirect   = ($urandom_range(0, 5) == 0);
      hif.halt_id       = ($urandom_range(0, 15) == 0);
      hif.halt_wb       = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
